// File: rtl/passcode_programmer.sv
// rtl/passcode_programmer.sv - passcode writer FSM: authenticate, enter, confirm, commit
// Optional PASSCODE_REJECT_TRIVIAL_EN rejects 8'h00, 8'hFF and the current code as a new code.
module passcode_programmer #(
  parameter logic [7:0] DEFAULT_CODE = 8'hA5,
  parameter int         HOLD_CYCLES  = 50_000_000,
  parameter int         LOCK_CYCLES  = 500_000_000,
  parameter int         MAX_FAIL     = 3
) (
  input  logic       clock_in,
  input  logic       clr,
  input  logic       prog_req,
  input  logic       enter,
  input  logic       cancel,
  input  logic [7:0] sw,
  output logic [7:0] code_out,
  output logic       busy,
  output logic       LED_ok,
  output logic       LED_err,
  output logic [1:0] fail_cnt,
  output logic [2:0] prog_state
);

  localparam int MAX_CYC = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AUTH = 3'd1,
    S_NEW1 = 3'd2,
    S_NEW2 = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5,
    S_LOCK = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    new_code;
  logic [7:0]    new_code_nx;
  logic [7:0]    code_nx;
  logic [1:0]    fail_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic [2:0]    fail_inc;
  logic          trivial_code;

  assign prog_state = state;
  assign fail_inc   = {1'b0, fail_cnt} + 3'd1;

`ifdef PASSCODE_REJECT_TRIVIAL_EN
  assign trivial_code = (sw == 8'h00) || (sw == 8'hFF) || (sw == code_out);
`else
  assign trivial_code = 1'b0;
`endif

  // cancel outranks enter; enter/cancel only matter in AUTH/NEW1/NEW2, prog_req only in IDLE
  always_comb begin
    state_nx    = state;
    code_nx     = code_out;
    new_code_nx = new_code;
    fail_nx     = fail_cnt;
    timer_nx    = timer;
    case (state)
      S_IDLE: begin
        if (prog_req) state_nx = S_AUTH;
      end
      S_AUTH: begin
        if (cancel) begin
          state_nx = S_IDLE;
        end else if (enter) begin
          if (sw == code_out) begin
            state_nx = S_NEW1;
            fail_nx  = 2'd0;
          end else begin
            if ({1'b0, fail_cnt} < FAIL_LIMIT) fail_nx = fail_inc[1:0];
            if (fail_inc >= FAIL_LIMIT) begin
              state_nx = S_LOCK;
              timer_nx = LOCK_LOAD;
            end else begin
              state_nx = S_ERR;
              timer_nx = HOLD_LOAD;
            end
          end
        end
      end
      S_NEW1: begin
        if (cancel) begin
          state_nx = S_IDLE;
        end else if (enter) begin
          if (trivial_code) begin
            state_nx = S_ERR;
            timer_nx = HOLD_LOAD;
          end else begin
            new_code_nx = sw;
            state_nx    = S_NEW2;
          end
        end
      end
      S_NEW2: begin
        if (cancel) begin
          state_nx = S_IDLE;
        end else if (enter) begin
          timer_nx = HOLD_LOAD;
          if (sw == new_code) begin
            code_nx  = sw;
            state_nx = S_DONE;
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (timer == '0) state_nx = S_IDLE;
        else             timer_nx = timer - TIMER_ONE;
      end
      S_LOCK: begin
        if (timer == '0) begin
          state_nx = S_IDLE;
          fail_nx  = 2'd0;
        end else begin
          timer_nx = timer - TIMER_ONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // indicators are decoded from the next state so they switch on the same edge as prog_state
  always_ff @(posedge clock_in) begin
    if (!clr) begin
      state    <= S_IDLE;
      code_out <= DEFAULT_CODE;
      new_code <= 8'h00;
      fail_cnt <= 2'd0;
      timer    <= '0;
      busy     <= 1'b0;
      LED_ok   <= 1'b0;
      LED_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      code_out <= code_nx;
      new_code <= new_code_nx;
      fail_cnt <= fail_nx;
      timer    <= timer_nx;
      busy     <= (state_nx != S_IDLE);
      LED_ok   <= (state_nx == S_DONE);
      LED_err  <= (state_nx == S_ERR) || (state_nx == S_LOCK);
    end
  end

endmodule

// File: tb/tb_passcode_programmer.sv
// tb/tb_passcode_programmer.sv - self-checking bench for passcode_programmer
// Honours PASSCODE_REJECT_TRIVIAL_EN when the build defines it.
module tb_passcode_programmer;

  localparam int HOLD = 4;
  localparam int LOCKC = 16;
  localparam int MAXF = 3;

  logic       clock_in = 0;
  logic       clr = 0;
  logic       prog_req = 0;
  logic       enter = 0;
  logic       cancel = 0;
  logic [7:0] sw = 8'h00;
  logic [7:0] code_out;
  logic       busy, LED_ok, LED_err;
  logic [1:0] fail_cnt;
  logic [2:0] prog_state;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // model: spec state numbers, code, fail count, remaining indicator cycles
  int       m_state = 0;
  int       m_fail = 0;
  int       m_left = 0;
  bit [7:0] m_code = 8'hA5;
  bit [7:0] m_new = 8'h00;

  passcode_programmer #(
    .DEFAULT_CODE(8'hA5), .HOLD_CYCLES(HOLD), .LOCK_CYCLES(LOCKC), .MAX_FAIL(MAXF)
  ) dut (
    .clock_in(clock_in), .clr(clr), .prog_req(prog_req), .enter(enter),
    .cancel(cancel), .sw(sw), .code_out(code_out), .busy(busy),
    .LED_ok(LED_ok), .LED_err(LED_err), .fail_cnt(fail_cnt),
    .prog_state(prog_state)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic bit trivial(input bit [7:0] v, input bit [7:0] cur);
`ifdef PASSCODE_REJECT_TRIVIAL_EN
    return (v == 8'h00) || (v == 8'hFF) || (v == cur);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock_in) begin
    if (!clr) begin
      m_state <= 0; m_code <= 8'hA5; m_fail <= 0; m_left <= 0; m_new <= 8'h00;
    end else if (m_state == 0) begin
      if (prog_req) m_state <= 1;
    end else if (m_state >= 4) begin
      if (m_left <= 1) begin
        m_state <= 0;
        if (m_state == 6) m_fail <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (cancel) begin
      m_state <= 0;
    end else if (enter) begin
      if (m_state == 1) begin
        if (sw == m_code) begin
          m_state <= 2; m_fail <= 0;
        end else if (m_fail + 1 == MAXF) begin
          m_state <= 6; m_fail <= m_fail + 1; m_left <= LOCKC;
        end else begin
          m_state <= 5; m_fail <= m_fail + 1; m_left <= HOLD;
        end
      end else if (m_state == 2) begin
        if (trivial(sw, m_code)) begin
          m_state <= 5; m_left <= HOLD;
        end else begin
          m_new <= sw; m_state <= 3;
        end
      end else begin
        m_left <= HOLD;
        if (sw == m_new) begin
          m_code <= sw; m_state <= 4;
        end else begin
          m_state <= 5;
        end
      end
    end
  end

  always @(negedge clock_in) begin
    if (chk_en) begin
      chk("cyc_state", int'(prog_state), m_state);
      chk("cyc_code", int'(code_out), int'(m_code));
      chk("cyc_fail", int'(fail_cnt), m_fail);
      chk("cyc_busy", int'(busy), int'(m_state != 0));
      chk("cyc_led_ok", int'(LED_ok), int'(m_state == 4));
      chk("cyc_led_err", int'(LED_err), int'(m_state == 5 || m_state == 6));
    end
  end

  task automatic pulse(input bit p, input bit e, input bit c, input bit [7:0] v);
    @(negedge clock_in);
    prog_req = p; enter = e; cancel = c; sw = v;
    @(negedge clock_in);
    prog_req = 0; enter = 0; cancel = 0;
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    clr = 0;
    repeat (2) @(negedge clock_in);
    clr = 1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (prog_state != 3'd0 && n < 40) begin
      @(negedge clock_in);
      n++;
    end
    chk(name, int'(prog_state), 0);
  endtask

  task automatic count_high(input string name, input bit which_ok, input int exp);
    int n;
    n = 0;
    while ((which_ok ? LED_ok : LED_err) && n < 40) begin
      n++;
      @(negedge clock_in);
    end
    chk(name, n, exp);
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_code", int'(code_out), 8'hA5);
    chk("rst_state", int'(prog_state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_leds", int'({LED_ok, LED_err}), 0);
    chk("rst_fail", int'(fail_cnt), 0);

    pulse(1, 0, 0, 8'h00);
    chk("ok_auth", int'(prog_state), 1);
    pulse(0, 1, 0, 8'hA5);
    chk("ok_new1", int'(prog_state), 2);
    pulse(0, 1, 0, 8'h3C);
    chk("ok_new2", int'(prog_state), 3);
    chk("ok_code_before", int'(code_out), 8'hA5);
    pulse(0, 1, 0, 8'h3C);
    chk("ok_done", int'(prog_state), 4);
    chk("ok_code_3c", int'(code_out), 8'h3C);
    count_high("ok_led_len", 1, 4);
    chk("ok_back_idle", int'(prog_state), 0);
    pulse(1, 0, 0, 8'h00);
    pulse(0, 1, 0, 8'h3C);
    chk("new_code_accepted", int'(prog_state), 2);
    pulse(0, 0, 1, 8'h00);

    do_reset();
    pulse(1, 0, 0, 8'h00);
    pulse(0, 1, 0, 8'hA5);
    pulse(0, 1, 0, 8'h3C);
    pulse(0, 1, 0, 8'h3D);
    chk("mm_err", int'(prog_state), 5);
    count_high("mm_led_len", 0, 4);
    chk("mm_code", int'(code_out), 8'hA5);
    chk("mm_fail", int'(fail_cnt), 0);

    for (int k = 1; k <= 3; k++) begin
      wait_idle("lk_idle_wait");
      pulse(1, 0, 0, 8'h00);
      pulse(0, 1, 0, 8'h00);
      chk("lk_fail", int'(fail_cnt), k);
      chk("lk_state", int'(prog_state), (k == 3) ? 6 : 5);
    end
    pulse(1, 0, 0, 8'h00);
    chk("lk_ignore_req", int'(prog_state), 6);
    count_high("lk_led_len", 0, 14);
    chk("lk_end_state", int'(prog_state), 0);
    chk("lk_end_fail", int'(fail_cnt), 0);

    pulse(1, 0, 0, 8'h00);
    pulse(0, 1, 0, 8'hA5);
    pulse(0, 1, 1, 8'h77);
    chk("cx_idle", int'(prog_state), 0);
    chk("cx_code", int'(code_out), 8'hA5);
    pulse(1, 0, 0, 8'h00);
    pulse(0, 1, 0, 8'hA5);
    pulse(0, 1, 0, 8'h5A);
    chk("cx_new2", int'(prog_state), 3);
    @(negedge clock_in);
    clr = 0;
    @(negedge clock_in);
    clr = 1;
    chk("cx_rst_state", int'(prog_state), 0);
    chk("cx_rst_code", int'(code_out), 8'hA5);
    chk("cx_rst_busy", int'(busy), 0);
    pulse(0, 1, 0, 8'h5A);
    chk("cx_enter_idle_ignored", int'(prog_state), 0);

    pulse(1, 0, 0, 8'h00);
    pulse(0, 1, 0, 8'hA5);
    pulse(0, 1, 0, 8'hFF);
`ifdef PASSCODE_REJECT_TRIVIAL_EN
    chk("triv_state", int'(prog_state), 5);
`else
    chk("triv_state", int'(prog_state), 3);
    pulse(0, 0, 1, 8'h00);
`endif
    chk("triv_code", int'(code_out), 8'hA5);
    wait_idle("triv_idle");

    repeat (2) @(negedge clock_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
